// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin through one full-subtractor cell, LSB first; done pulses WIDTH+1 edges after start.
// No backpressure: start is only taken in IDLE, and a requester that is not ready simply waits there.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_b;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_sa_nxt;

  // Shared full-subtractor cell on the current LSBs
  assign w_d    = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_bout = (~r_sa[0] & r_br) | (~r_sa[0] & r_sb[0]) | (r_sb[0] & r_br);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Difference bits fill the minuend register from the top as its bits are consumed,
  // so after WIDTH shifts it holds the full result.
  assign w_sa_nxt = {w_d, r_sa[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_b     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_sa  <= w_sa_nxt;
            r_sb  <= r_sb >> 1;
            r_br  <= w_bout;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_d     <= w_sa_nxt;
              r_b     <= w_bout;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign B    = r_b;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: stimulus pushes arithmetic expectations, a negedge monitor pops on done.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         B;

  int total = 0;
  int bad   = 0;

  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;
  logic [W-1:0] last_d;
  logic         last_b;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .B     (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {B, D}, mon_e);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                       input int abort_at, input bit mid_start, input bit keep_start,
                       input bit with_abort);
    int         diff;
    logic [W:0] ev;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("hold", {B, D}, {last_b, last_d});
    start = 1'b1; a = ai; b = bi; bin = bini; abort = with_abort;
    diff = int'(ai) - int'(bi) - int'(bini);
    if (abort_at < 0) begin
      ev = {(diff < 0) ? 1'b1 : 1'b0, diff[W-1:0]};
      exp_q.push_back(ev);
      last_b = ev[W];
      last_d = ev[W-1:0];
    end
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      abort = 1'b0;
      if (mid_start && k == 3) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hold", {B, D}, {last_b, last_d});
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    if (keep_start) begin
      start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int ab;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_d = '0; last_b = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_B", B, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, -1, 0, 0, 0);
    do_op(8'h00, 8'h01, 1'b0, -1, 0, 0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, -1, 0, 0, 0);
    do_op(8'h80, 8'h7F, 1'b1, -1, 0, 0, 0);
    do_op(8'h01, 8'h00, 1'b1, -1, 0, 0, 0);
    // Start during RUN is ignored; start held through DONE is not taken until IDLE
    do_op(8'h5A, 8'h3C, 1'b0, -1, 1, 1, 0);
    do_op(8'hC3, 8'h41, 1'b0, -1, 0, 0, 0);
    do_op(8'h77, 8'h11, 1'b0, 4, 0, 0, 0);
    do_op(8'h33, 8'h22, 1'b1, -1, 0, 0, 1);

    // Asynchronous reset in RUN cycle 5
    @(negedge clk);
    start = 1'b1; a = 8'h9C; b = 8'h27; bin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_D", D, 0);
    chk("midrst_B", B, 0);
    last_d = '0; last_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, -1, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : -1;
      do_op(W'($urandom), W'($urandom), 1'($urandom), ab,
            (ab < 0) ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller: computes D = a - b - bin over WIDTH-bit operands.
- Time-shares a single full-subtractor cell, one bit per clock, LSB first. The cell's logic is D = a^b^bin and B = (~a&bin)|(~a&b)|(b&bin).
- A registered borrow carries between bits.
- Sits between a requester (start/done handshake) and the shared subtractor datapath, sequencing operand shifting, borrow propagation and result assembly.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- abort  input  1  synchronous cancel of an operation in progress.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  initial borrow-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when D/B are updated.
- D  output  WIDTH  registered difference; holds the last completed result.
- B  output  1  registered final borrow-out; holds the last completed result.

Behaviour:

Reset:
- rst_n low forces, asynchronously: state=IDLE, busy=0, done=0, D=0, B=0, internal shift registers/borrow/count = 0.
- Release is synchronous to clk.

States:
- IDLE: waiting for start.
- RUN: processing one bit per cycle.
- DONE: one cycle; done=1.

Transitions:
- IDLE -> RUN when start=1 at an edge.
  - Capture a, b into shift registers sa/sb; borrow register br <= bin; count <= 0.
- RUN, each edge with abort=0:
  - d = sa[0]^sb[0]^br.
  - br <= (~sa[0]&br)|(~sa[0]&sb[0])|(sb[0]&br).
  - Partial result register shifts right with d entering at MSB; sa/sb shift right; count++.
- RUN -> DONE at the edge processing bit WIDTH-1 (count==WIDTH-1).
  - D <= final partial result (including that bit); B <= final borrow.
- DONE -> IDLE unconditionally at the next edge.
- RUN with abort=1 -> IDLE at that edge.
  - No done pulse; D/B keep their previous values; partial work is discarded.
- abort is ignored in IDLE and DONE.

Outputs:
- busy=1 exactly in RUN.
- done=1 exactly in DONE; it is asserted in the same cycle D/B first show the new result.

Latency:
- start sampled at edge 0 -> busy high cycles 1..WIDTH -> done high for the cycle after edge WIDTH.
- Start-to-done is WIDTH+1 edges; throughput is one operation per WIDTH+2 cycles.

Handshake:
- start is ignored in RUN and DONE; there is no queuing, and the requester must re-assert start in IDLE.
- start held high continuously restarts immediately on return to IDLE; a, b, bin are re-sampled then.
- a/b/bin are don't-care except at the accepting edge.

Arithmetic:
- Result is modulo 2^WIDTH.
- B=1 iff a < b + bin (unsigned).

Simultaneous events:
- start and abort together in IDLE: start wins (abort ignored).
- rst_n low at any time overrides everything, including mid-RUN.
  - D/B are cleared to 0 and no done pulse is produced.

Test Plan:
- Basic subtraction: WIDTH=8, a=0x5A, b=0x3C, bin=0, start at edge 0 -> busy for 8 cycles; done pulse after edge 8; D=0x1E, B=0; D/B hold after return to IDLE.
- Underflow: a=0x00, b=0x01, bin=0 -> D=0xFF, B=1. Then a=0xFF, b=0xFF, bin=1 -> D=0xFF, B=1.
- Zero result with borrow-in: a=0x80, b=0x7F, bin=1 -> D=0x00, B=0. Then a=0x01, b=0x00, bin=1 -> D=0x00, B=0.
- Start while busy: start pulsed at cycle 3 of RUN with different operands -> ignored; first result (0x1E) delivered; start held high through DONE -> new operation begins exactly one cycle after done.
- Abort: abort=1 at RUN cycle 4 -> IDLE next edge; busy=0; no done; D/B unchanged from prior result. Start+abort together in IDLE -> operation starts.
- Reset mid-operation: rst_n low at RUN cycle 5 -> busy, done, D, B go to 0 immediately without a clock edge; after release, a fresh run a=0x10, b=0x01 -> D=0x0F, B=0.
